mem_stage_unit: RTL and testbench
=================================

MEM_STAGE_UNIT -- requirements
Module: mem_stage_unit

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of data-memory size in 32-bit words.
REQ-002 SHALL have parameter LAT, default 2, access latency in cycles, legal range 1..7.
REQ-003 SHALL have port Clk  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  access request present.
REQ-006 SHALL have port req_op  in  3  access type: LW, LH, LHU, LB, LBU, SW, SH, SB.
REQ-007 SHALL have ports req_addr/req_wdata/req_pc  in  32 each  byte address, store data (forwarded), instruction PC.
REQ-008 SHALL have port req_a3  in  5  destination register; ignored for stores.
REQ-009 SHALL have port flush  in  1  abort any in-flight access.
REQ-010 SHALL have port busy  out  1  access in progress; upstream holds its request while high.
REQ-011 SHALL have ports rd_valid (1), rd_data (32), rd_a3 (5), rd_pc (32), exc (1)  out  completion result to writeback.

Function
REQ-012 SHALL implement FSM IDLE/ACCESS with a 3-bit latency counter.
REQ-013 SHALL accept a request on an edge where state==IDLE, req_valid=1 and flush=0, capturing op/addr/wdata/pc/a3 and entering ACCESS.
REQ-014 SHALL hold busy=1 for exactly LAT cycles after acceptance, ignoring req_valid while busy.
REQ-015 SHALL, at the edge ending the LAT-th ACCESS cycle, perform the memory operation, load the rd_* registers, set rd_valid=1 for one cycle and return to IDLE.
REQ-016 SHALL accept a new request in the same cycle rd_valid is high, giving back-to-back throughput of one access per LAT+1 cycles.
REQ-017 SHALL index memory with addr[DEPTH_LOG2+1:2]; higher address bits are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2 bytes.
REQ-018 SHALL write SB/SH/SW with byte enables from addr[1:0] (SB: one lane; SH: lanes addr[1]*2..+1; SW: all four), storing low bytes of req_wdata.
REQ-019 SHALL sign-extend LB/LH, zero-extend LBU/LHU, and pass LW unmodified, selecting the byte or half lane by addr[1:0].
REQ-020 SHALL drive rd_a3=0 and rd_data=0 for stores, while still pulsing rd_valid.
REQ-021 SHALL, on flush in ACCESS, abandon the access with no memory write and no rd_valid, returning to IDLE next cycle; flush with req_valid in IDLE rejects the request.
REQ-022 SHALL give a load issued after a store to the same word, accepted the cycle rd_valid of the store is high, the stored value.

Reset
REQ-023 SHALL, on Reset, set state=IDLE, counter=0, busy=0, rd_valid=0, rd_data=0, rd_a3=0, rd_pc=0, exc=0.
REQ-024 SHALL clear every memory word to 0 on Reset.
REQ-025 SHALL let Reset win over flush and req_valid; Reset mid-ACCESS aborts with no write.

Configuration
REQ-026 SHALL, with macro MEM_ALIGN_EXC_EN defined, treat LW/SW with addr[1:0]!=0 and LH/LHU/SH with addr[0]!=0 as misaligned: no write, rd_data=0, rd_a3=0, exc=1 alongside rd_valid.
REQ-027 SHALL, without MEM_ALIGN_EXC_EN, force misaligned word/half accesses aligned by ignoring the offending low address bits, with exc tied 0.

Structure
REQ-028 SHALL take the req_op encodings, FSM state encoding and LAT range limits from shared package mem_pkg.
REQ-029 SHALL place the byte-lane extract/extend and write-merge logic in one sub-module, mem_lane_align.

Verification
REQ-030 SHALL cover, with LAT=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rd_valid 2 cycles after each accept, rd_data=0xDEADBEEF.
REQ-031 SHALL cover: SB 0x13 data 0x000000F0 into word 0x11223344, then LB 0x13 -> 0xFFFFFFF0; LBU 0x13 -> 0x000000F0; LW 0x10 -> 0xF0223344.
REQ-032 SHALL cover: SH 0x22 data 0x8001, then LH 0x22 -> 0xFFFF8001, LHU 0x22 -> 0x00008001.
REQ-033 SHALL cover: SW accepted, flush asserted 1 cycle later -> no rd_valid; LW same address returns the old value.
REQ-034 SHALL cover, with DEPTH_LOG2=4: SW addr 0x40 data 5, then LW 0x00 -> 5 (wrap).
REQ-035 SHALL cover, with MEM_ALIGN_EXC_EN: LW addr 0x02 -> exc=1, rd_a3=0; SW addr 0x01 -> exc=1, memory unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: access-type encodings, FSM state
// encoding and the legal range of the access latency.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mem_stage_unit_if.sv
// Request/completion bundle between the pipeline and the memory stage.
// Handshake: a request is taken on a rising edge where the unit is idle,
// req_valid=1 and flush=0; upstream keeps its request stable while busy=1.
// rd_valid is a single-cycle completion pulse with no back-pressure.
interface mem_stage_unit_if;
  import mem_pkg::*;

  logic        req_valid;
  mem_op_e     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic [4:0]  req_a3;
  logic        flush;
  logic        busy;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [4:0]  rd_a3;
  logic [31:0] rd_pc;
  logic        exc;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_pc, req_a3, flush,
    input  busy, rd_valid, rd_data, rd_a3, rd_pc, exc
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_pc, req_a3, flush,
    output busy, rd_valid, rd_data, rd_a3, rd_pc, exc
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane logic: extracts and sign/zero-extends load data, merges store
// data into the old word, and flags misaligned word/half accesses.
// Word/half accesses always use the offset with offending low bits cleared.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter bit ALIGN_EXC = 1'b0
) (
  input  mem_op_e     op,
  input  logic [1:0]  off,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [1:0]  eff;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane selection, load extension and store merge.
  always_comb begin
    misaligned = 1'b0;
    eff        = off;
    case (op)
      OP_LW, OP_SW: begin
        misaligned = ALIGN_EXC && (off != 2'b00);
        eff        = 2'b00;
      end
      OP_LH, OP_LHU, OP_SH: begin
        misaligned = ALIGN_EXC && off[0];
        eff        = {off[1], 1'b0};
      end
      default: eff = off;
    endcase

    sel_byte = old_word[{eff, 3'b000} +: 8];
    sel_half = old_word[{eff[1], 4'b0000} +: 16];

    case (op)
      OP_LW:   load_data = old_word;
      OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_data = {16'h0000, sel_half};
      OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_data = {24'h000000, sel_byte};
      default: load_data = 32'h0;
    endcase

    merged = old_word;
    case (op)
      OP_SW:   merged = wdata;
      OP_SH:   merged[{eff[1], 4'b0000} +: 16] = wdata[15:0];
      OP_SB:   merged[{eff, 3'b000} +: 8] = wdata[7:0];
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_unit.sv
// Memory stage: multi-cycle data-memory access with fixed latency LAT.
// Optional feature macro MEM_ALIGN_EXC_EN: misaligned word/half accesses
// raise exc instead of being forced aligned.
module mem_stage_unit
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LAT        = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_stage_unit_if.slave   bus,
  output mem_state_e        dbg_state
);

  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
    $error("mem_stage_unit: LAT out of range");
  end

`ifdef MEM_ALIGN_EXC_EN
  localparam bit ALIGN_EXC = 1'b1;
`else
  localparam bit ALIGN_EXC = 1'b0;
`endif

  localparam logic [2:0] LAT_LAST = 3'(LAT - 1);

  mem_state_e state, state_nx;
  logic [2:0] cnt;
  logic       accept, done;

  mem_op_e               cap_op;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [1:0]            cap_off;
  logic [31:0]           cap_wdata, cap_pc;
  logic [4:0]            cap_a3;

  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] merged, load_data;
  logic        misaligned;

  logic        rd_valid_q, exc_q;
  logic [31:0] rd_data_q, rd_pc_q;
  logic [4:0]  rd_a3_q;

  // Next-state: accept when idle, count latency, flush aborts.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          state_nx = ST_ACCESS;
          accept   = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (bus.flush) begin
          state_nx = ST_IDLE;
        end else if (cnt == LAT_LAST) begin
          state_nx = ST_IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register and latency counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx == ST_ACCESS && !accept) ? cnt + 3'd1 : 3'd0;
    end
  end

  // Capture the request on acceptance.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cap_op    <= OP_LW;
      cap_idx   <= '0;
      cap_off   <= 2'b00;
      cap_wdata <= 32'h0;
      cap_pc    <= 32'h0;
      cap_a3    <= 5'd0;
    end else if (accept) begin
      cap_op    <= bus.req_op;
      cap_idx   <= bus.req_addr[DEPTH_LOG2+1:2];
      cap_off   <= bus.req_addr[1:0];
      cap_wdata <= bus.req_wdata;
      cap_pc    <= bus.req_pc;
      cap_a3    <= bus.req_a3;
    end
  end

  mem_lane_align #(.ALIGN_EXC(ALIGN_EXC)) u_lane (
    .op        (cap_op),
    .off       (cap_off),
    .old_word  (mem[cap_idx]),
    .wdata     (cap_wdata),
    .merged    (merged),
    .load_data (load_data),
    .misaligned(misaligned)
  );

  // Data memory: cleared on reset, written only at completion of a valid store.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 2**DEPTH_LOG2; i++) mem[i] <= 32'h0;
    end else if (done && is_store(cap_op) && !misaligned) begin
      mem[cap_idx] <= merged;
    end
  end

  // Completion registers toward writeback.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0;
      rd_a3_q    <= 5'd0;
      rd_pc_q    <= 32'h0;
      exc_q      <= 1'b0;
    end else begin
      rd_valid_q <= done;
      if (done) begin
        rd_pc_q <= cap_pc;
        exc_q   <= misaligned;
        if (is_store(cap_op) || misaligned) begin
          rd_data_q <= 32'h0;
          rd_a3_q   <= 5'd0;
        end else begin
          rd_data_q <= load_data;
          rd_a3_q   <= cap_a3;
        end
      end
    end
  end

  assign bus.busy     = (state == ST_ACCESS);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_a3    = rd_a3_q;
  assign bus.rd_pc    = rd_pc_q;
  assign bus.exc      = exc_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit (DEPTH_LOG2=4, LAT=2).
module tb_mem_stage_unit;
  import mem_pkg::*;

  localparam int LAT = 2;

  logic Clk = 1'b0;
  logic Reset;
  mem_state_e dbg_state;
  int pass_cnt = 0;
  int total_cnt = 0;

  mem_stage_unit_if bus ();

  mem_stage_unit #(.DEPTH_LOG2(4), .LAT(LAT)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  // Issue one request (called #1 after a rising edge) and wait for rd_valid.
  task automatic do_access(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] pc, input logic [4:0] a3,
                           output logic [31:0] data, output logic [4:0] ra3,
                           output logic [31:0] rpc, output logic e, output int lat);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_pc    = pc;
    bus.req_a3    = a3;
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.rd_valid !== 1'b1 && lat < 10) begin
      @(posedge Clk); #1;
      lat++;
    end
    if (lat >= 10) lat = -1;
    data = bus.rd_data;
    ra3  = bus.rd_a3;
    rpc  = bus.rd_pc;
    e    = bus.exc;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.req_valid = 1'b1;
    bus.flush = 1'b1;
    bus.req_op = OP_SW;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_pc = 32'h0;
    bus.req_a3 = 5'd0;
    repeat (3) @(posedge Clk);
    #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %0b want 0", bus.rd_valid); else pass_cnt++;
    total_cnt++; if (bus.rd_data !== 32'h0) $display("FAIL reset_rd_data got %h want 0", bus.rd_data); else pass_cnt++;
    total_cnt++; if (bus.rd_a3 !== 5'd0 || bus.rd_pc !== 32'h0 || bus.exc !== 1'b0)
      $display("FAIL reset_rd_regs got a3=%h pc=%h exc=%b want 0", bus.rd_a3, bus.rd_pc, bus.exc); else pass_cnt++;
    total_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state got %0d want IDLE", dbg_state); else pass_cnt++;
    Reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_sw_lw();
    logic [31:0] d, p; logic [4:0] a; logic e; int lat;
    do_access(OP_SW, 32'h10, 32'hDEADBEEF, 32'h100, 5'd7, d, a, p, e, lat);
    total_cnt++; if (lat !== LAT) $display("FAIL sw_latency got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (d !== 32'h0 || a !== 5'd0 || e !== 1'b0)
      $display("FAIL sw_result got data=%h a3=%h exc=%b want 0/0/0", d, a, e); else pass_cnt++;
    total_cnt++; if (p !== 32'h100) $display("FAIL sw_pc got %h want 00000100", p); else pass_cnt++;
    do_access(OP_LW, 32'h10, 32'h0, 32'h104, 5'd5, d, a, p, e, lat);
    total_cnt++; if (lat !== LAT) $display("FAIL lw_latency got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (d !== 32'hDEADBEEF) $display("FAIL lw_data got %h want deadbeef", d); else pass_cnt++;
    total_cnt++; if (a !== 5'd5 || p !== 32'h104) $display("FAIL lw_a3_pc got a3=%0d pc=%h want 5/00000104", a, p); else pass_cnt++;
  endtask

  task automatic test_byte();
    logic [31:0] d, p; logic [4:0] a; logic e; int lat;
    do_access(OP_SW, 32'h10, 32'h11223344, 32'h0, 5'd1, d, a, p, e, lat);
    do_access(OP_SB, 32'h13, 32'h000000F0, 32'h0, 5'd1, d, a, p, e, lat);
    do_access(OP_LB, 32'h13, 32'h0, 32'h0, 5'd2, d, a, p, e, lat);
    total_cnt++; if (d !== 32'hFFFFFFF0) $display("FAIL lb_neg got %h want fffffff0", d); else pass_cnt++;
    do_access(OP_LBU, 32'h13, 32'h0, 32'h0, 5'd2, d, a, p, e, lat);
    total_cnt++; if (d !== 32'h000000F0) $display("FAIL lbu got %h want 000000f0", d); else pass_cnt++;
    do_access(OP_LW, 32'h10, 32'h0, 32'h0, 5'd2, d, a, p, e, lat);
    total_cnt++; if (d !== 32'hF0223344) $display("FAIL sb_merge got %h want f0223344", d); else pass_cnt++;
    do_access(OP_LB, 32'h12, 32'h0, 32'h0, 5'd2, d, a, p, e, lat);
    total_cnt++; if (d !== 32'h00000022) $display("FAIL lb_pos got %h want 00000022", d); else pass_cnt++;
  endtask

  task automatic test_half();
    logic [31:0] d, p; logic [4:0] a; logic e; int lat;
    do_access(OP_SH, 32'h22, 32'h00008001, 32'h0, 5'd3, d, a, p, e, lat);
    do_access(OP_LH, 32'h22, 32'h0, 32'h0, 5'd3, d, a, p, e, lat);
    total_cnt++; if (d !== 32'hFFFF8001) $display("FAIL lh got %h want ffff8001", d); else pass_cnt++;
    do_access(OP_LHU, 32'h22, 32'h0, 32'h0, 5'd3, d, a, p, e, lat);
    total_cnt++; if (d !== 32'h00008001) $display("FAIL lhu got %h want 00008001", d); else pass_cnt++;
    do_access(OP_LW, 32'h20, 32'h0, 32'h0, 5'd3, d, a, p, e, lat);
    total_cnt++; if (d !== 32'h80010000) $display("FAIL sh_merge got %h want 80010000", d); else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [31:0] d, p; logic [4:0] a; logic e; int lat; int seen;
    bus.req_valid = 1'b1; bus.req_op = OP_SW; bus.req_addr = 32'h10;
    bus.req_wdata = 32'hCAFEF00D; bus.req_pc = 32'h200; bus.req_a3 = 5'd9;
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL flush_accept_busy got %0b want 1", bus.busy); else pass_cnt++;
    bus.flush = 1'b1;
    @(posedge Clk); #1;
    bus.flush = 1'b0;
    total_cnt++; if (dbg_state !== ST_IDLE || bus.busy !== 1'b0)
      $display("FAIL flush_abort got state=%0d busy=%0b want IDLE/0", dbg_state, bus.busy); else pass_cnt++;
    seen = 0;
    repeat (4) begin
      if (bus.rd_valid === 1'b1) seen++;
      @(posedge Clk); #1;
    end
    total_cnt++; if (seen !== 0) $display("FAIL flush_no_rd_valid got %0d pulses want 0", seen); else pass_cnt++;
    do_access(OP_LW, 32'h10, 32'h0, 32'h0, 5'd4, d, a, p, e, lat);
    total_cnt++; if (d !== 32'hF0223344) $display("FAIL flush_no_write got %h want f0223344", d); else pass_cnt++;
    // Flush together with a request while idle rejects it.
    bus.req_valid = 1'b1; bus.flush = 1'b1; bus.req_op = OP_SW; bus.req_addr = 32'h10;
    @(posedge Clk); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL flush_idle_reject got busy=%0b want 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [31:0] d, p; logic [4:0] a; logic e; int lat;
    do_access(OP_SW, 32'h40, 32'h00000005, 32'h0, 5'd1, d, a, p, e, lat);
    do_access(OP_LW, 32'h00, 32'h0, 32'h0, 5'd1, d, a, p, e, lat);
    total_cnt++; if (d !== 32'h00000005) $display("FAIL wrap got %h want 00000005", d); else pass_cnt++;
  endtask

  task automatic test_align();
    logic [31:0] d, p; logic [4:0] a; logic e; int lat;
    do_access(OP_SW, 32'h00, 32'h55667788, 32'h0, 5'd1, d, a, p, e, lat);
`ifdef MEM_ALIGN_EXC_EN
    do_access(OP_LW, 32'h02, 32'h0, 32'h0, 5'd6, d, a, p, e, lat);
    total_cnt++; if (e !== 1'b1 || a !== 5'd0 || d !== 32'h0)
      $display("FAIL misalign_lw got exc=%b a3=%0d data=%h want 1/0/0", e, a, d); else pass_cnt++;
    do_access(OP_SW, 32'h01, 32'hFFFFFFFF, 32'h0, 5'd6, d, a, p, e, lat);
    total_cnt++; if (e !== 1'b1) $display("FAIL misalign_sw_exc got %b want 1", e); else pass_cnt++;
    do_access(OP_LW, 32'h00, 32'h0, 32'h0, 5'd6, d, a, p, e, lat);
    total_cnt++; if (d !== 32'h55667788 || e !== 1'b0)
      $display("FAIL misalign_sw_nowrite got %h exc=%b want 55667788/0", d, e); else pass_cnt++;
`else
    do_access(OP_LW, 32'h02, 32'h0, 32'h0, 5'd6, d, a, p, e, lat);
    total_cnt++; if (d !== 32'h55667788 || e !== 1'b0 || a !== 5'd6)
      $display("FAIL force_align_lw got %h exc=%b a3=%0d want 55667788/0/6", d, e, a); else pass_cnt++;
    do_access(OP_SW, 32'h01, 32'hAABBCCDD, 32'h0, 5'd6, d, a, p, e, lat);
    total_cnt++; if (e !== 1'b0) $display("FAIL force_align_sw_exc got %b want 0", e); else pass_cnt++;
    do_access(OP_LW, 32'h00, 32'h0, 32'h0, 5'd6, d, a, p, e, lat);
    total_cnt++; if (d !== 32'hAABBCCDD) $display("FAIL force_align_sw got %h want aabbccdd", d); else pass_cnt++;
    do_access(OP_LH, 32'h03, 32'h0, 32'h0, 5'd6, d, a, p, e, lat);
    total_cnt++; if (d !== 32'hFFFFAABB) $display("FAIL force_align_lh got %h want ffffaabb", d); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_abort();
    logic [31:0] d, p; logic [4:0] a; logic e; int lat;
    bus.req_valid = 1'b1; bus.req_op = OP_SW; bus.req_addr = 32'h30;
    bus.req_wdata = 32'h12345678; bus.req_pc = 32'h0; bus.req_a3 = 5'd0;
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    total_cnt++; if (dbg_state !== ST_IDLE || bus.rd_valid !== 1'b0)
      $display("FAIL reset_abort got state=%0d rd_valid=%0b want IDLE/0", dbg_state, bus.rd_valid); else pass_cnt++;
    do_access(OP_LW, 32'h30, 32'h0, 32'h0, 5'd1, d, a, p, e, lat);
    total_cnt++; if (d !== 32'h0) $display("FAIL reset_abort_nowrite got %h want 0", d); else pass_cnt++;
    do_access(OP_LW, 32'h10, 32'h0, 32'h0, 5'd1, d, a, p, e, lat);
    total_cnt++; if (d !== 32'h0) $display("FAIL reset_clears_mem got %h want 0", d); else pass_cnt++;
    total_cnt++; if (lat !== LAT) $display("FAIL reset_timeout got lat %0d want %0d", lat, LAT); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_flush();
    test_wrap();
    test_align();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
